// File: rtl/bus_capture_engine.sv
`default_nettype none
// ============================================================================
// Module : bus_capture_engine
// Brief  : C64 bus logic analyser that captures bus cycles into a circular RAM
//          with arm/trigger/post-trigger sequencing and a registered read port.
// Rev    : 1.0
// ============================================================================
module bus_capture_engine #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          c64_addr,
  input  logic [DATA_W-1:0]          c64_data,
  input  logic                       c64_rw,
  input  logic                       c64_phi2,
  input  logic                       c64_irq_n,
  input  logic                       c64_nmi_n,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [1:0]                 mode,
  input  logic [ADDR_W-1:0]          trig_addr,
  input  logic [ADDR_W-1:0]          trig_mask,
  input  logic [1:0]                 trig_rw,
  input  logic                       ext_trig_en,
  input  logic                       ext_trig,
  input  logic [DEPTH_LOG2-1:0]      post_count,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       done,
  output logic                       wrapped,
  output logic [DEPTH_LOG2-1:0]      wr_ptr,
  output logic [DEPTH_LOG2-1:0]      trig_index,
  input  logic [DEPTH_LOG2-1:0]      read_addr,
  output logic [ADDR_W+DATA_W+2:0]   read_data
);

  localparam int SAMPLE_W = ADDR_W + DATA_W + 3;
  localparam int DEPTH    = 2 ** DEPTH_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            cur_state;
  logic [1:0]            nxt_state;
  logic                  phi2_q;
  logic                  se;
  logic                  rw_ok;
  logic                  addr_match;
  logic                  hit;
  logic                  store;
  logic                  start;
  logic [DEPTH_LOG2-1:0] remaining;
  logic [SAMPLE_W-1:0]   word;
  logic [SAMPLE_W-1:0]   mem [DEPTH];

  assign word = {c64_nmi_n, c64_irq_n, c64_rw, c64_data, c64_addr};

  always_comb begin
    case (mode)
      2'b00:   se = 1'b1;
      2'b01:   se = phi2_q & ~c64_phi2;
      2'b10:   se = ~phi2_q & c64_phi2;
      default: se = phi2_q ^ c64_phi2;
    endcase
  end

  always_comb begin
    case (trig_rw)
      2'b00:   rw_ok = 1'b1;
      2'b01:   rw_ok = c64_rw;
      2'b10:   rw_ok = ~c64_rw;
      default: rw_ok = 1'b0;
    endcase
  end

  assign addr_match = (((c64_addr ^ trig_addr) & trig_mask) == '0);
  assign hit        = se & ((addr_match & rw_ok) | (ext_trig_en & ext_trig));

  // Abort freezes everything, including a sample that would land in the same cycle.
  assign store = ~abort & se & ((cur_state == S_ARMED) | (cur_state == S_POST));
  assign start = ~abort & arm & ((cur_state == S_IDLE) | (cur_state == S_DONE));

  always_ff @(posedge clk_sys) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:  if (arm) nxt_state = S_ARMED;
      S_ARMED: if (hit) nxt_state = (post_count == '0) ? S_DONE : S_POST;
      S_POST:  if (se && remaining == DEPTH_LOG2'(1)) nxt_state = S_DONE;
      default: if (arm) nxt_state = S_ARMED;
    endcase
    if (abort) nxt_state = S_IDLE;
  end

  always_comb begin
    state = cur_state;
    done  = (cur_state == S_DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      phi2_q     <= 1'b0;
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      triggered  <= 1'b0;
      trig_index <= '0;
      remaining  <= '0;
    end else begin
      phi2_q <= c64_phi2;
      if (start) begin
        wr_ptr     <= '0;
        wrapped    <= 1'b0;
        triggered  <= 1'b0;
        trig_index <= '0;
      end else if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == '1) wrapped <= 1'b1;
        if (cur_state == S_ARMED && hit) begin
          trig_index <= wr_ptr;
          triggered  <= 1'b1;
          remaining  <= post_count;
        end else if (cur_state == S_POST) begin
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (store) mem[wr_ptr] <= word;
  end

  // Read-before-write: a same-cycle write to read_addr returns the old word.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) read_data <= '0;
    else        read_data <= mem[read_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_capture_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_capture_engine
// Brief  : Directed and random stimulus for bus_capture_engine against a
//          cycle-level reference model of the capture rules.
// Rev    : 1.0
// ============================================================================
module tb_bus_capture_engine;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] c64_addr;
  logic [7:0]  c64_data;
  logic        c64_rw, c64_phi2, c64_irq_n, c64_nmi_n;
  logic        arm, abort;
  logic [1:0]  mode;
  logic [15:0] trig_addr, trig_mask;
  logic [1:0]  trig_rw;
  logic        ext_trig_en, ext_trig;
  logic [9:0]  post_count;
  logic [1:0]  state;
  logic        triggered, done, wrapped;
  logic [9:0]  wr_ptr, trig_index, read_addr;
  logic [26:0] read_data;

  int tests = 0;
  int fails = 0;

  bus_capture_engine #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(10)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .c64_addr(c64_addr), .c64_data(c64_data),
    .c64_rw(c64_rw), .c64_phi2(c64_phi2), .c64_irq_n(c64_irq_n), .c64_nmi_n(c64_nmi_n),
    .arm(arm), .abort(abort), .mode(mode), .trig_addr(trig_addr), .trig_mask(trig_mask),
    .trig_rw(trig_rw), .ext_trig_en(ext_trig_en), .ext_trig(ext_trig),
    .post_count(post_count), .state(state), .triggered(triggered), .done(done),
    .wrapped(wrapped), .wr_ptr(wr_ptr), .trig_index(trig_index),
    .read_addr(read_addr), .read_data(read_data)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: capture phase as an int, buffer as a plain array.
  int          m_phase;      // 0 idle, 1 armed, 2 post, 3 done
  int          m_count;      // samples stored this capture
  bit          m_wrapped, m_trig;
  int          m_tidx, m_left;
  bit          m_phi_prev;
  logic [26:0] m_buf [1024];
  bit          m_known [1024];
  logic [26:0] m_rd;
  bit          m_rd_known;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit sample, hit, rw_ok;
    int slot;
    if (!rst_n) begin
      m_phase = 0; m_count = 0; m_wrapped = 0; m_trig = 0; m_tidx = 0; m_left = 0;
      m_phi_prev = 0; m_rd = 0; m_rd_known = 1;
      return;
    end
    m_rd_known = m_known[read_addr];
    m_rd       = m_buf[read_addr];
    case (mode)
      2'd0: sample = 1;
      2'd1: sample = m_phi_prev && !c64_phi2;
      2'd2: sample = !m_phi_prev && c64_phi2;
      default: sample = m_phi_prev != c64_phi2;
    endcase
    m_phi_prev = c64_phi2;
    rw_ok = (trig_rw == 0) || (trig_rw == 1 && c64_rw) || (trig_rw == 2 && !c64_rw);
    hit = sample && ((rw_ok && ((c64_addr ^ trig_addr) & trig_mask) == 0) ||
                     (ext_trig_en && ext_trig));
    if (abort) begin
      m_phase = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (arm) begin
        m_phase = 1; m_count = 0; m_wrapped = 0; m_trig = 0; m_tidx = 0;
      end
    end else if (sample) begin
      slot = m_count % 1024;
      m_buf[slot]   = {c64_nmi_n, c64_irq_n, c64_rw, c64_data, c64_addr};
      m_known[slot] = 1;
      m_count++;
      if (m_count >= 1024) m_wrapped = 1;
      if (m_phase == 1) begin
        if (hit) begin
          m_trig = 1; m_tidx = slot;
          if (post_count == 0) m_phase = 3;
          else begin m_left = post_count; m_phase = 2; end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_sys);
    #1;
    chk("state", 32'(state), 32'(m_phase));
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("wrapped", 32'(wrapped), 32'(m_wrapped));
    chk("wr_ptr", 32'(wr_ptr), 32'(m_count % 1024));
    chk("trig_index", 32'(trig_index), 32'(m_tidx));
    if (m_rd_known) chk("read_data", 32'(read_data), 32'(m_rd));
  endtask

  task automatic bus(input logic [15:0] a, input logic rw);
    c64_addr  = a;
    c64_rw    = rw;
    c64_data  = 8'($urandom);
    c64_irq_n = 1'($urandom);
    c64_nmi_n = 1'($urandom);
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  logic [15:0] a;
  logic [26:0] exp_word;

  initial begin
    rst_n = 0; arm = 0; abort = 0; mode = 0; trig_addr = 0; trig_mask = 0; trig_rw = 2'd3;
    ext_trig_en = 0; ext_trig = 0; post_count = 0; read_addr = 0; c64_phi2 = 0;
    bus(16'h1234, 1);
    tick(); tick();
    chk("reset_state", 32'(state), 0);
    chk("reset_wr_ptr", 32'(wr_ptr), 0);
    chk("reset_read_data", 32'(read_data), 0);
    rst_n = 1;

    // Address trigger on FFFE at sample 10, four post samples
    trig_addr = 16'hFFFE; trig_mask = 16'hFFFF; trig_rw = 0; post_count = 4;
    do_arm();
    for (int i = 0; i < 15; i++) begin
      bus((i == 10) ? 16'hFFFE : 16'(i), 1'($urandom));
      tick();
      if (i == 10) chk("s1_post", 32'(state), 2);
    end
    chk("s1_trig_index", 32'(trig_index), 10);
    chk("s1_done", 32'(done), 1);
    chk("s1_wr_ptr", 32'(wr_ptr), 15);
    for (int i = 0; i < 16; i++) begin read_addr = 10'(i); tick(); end

    // PHI2 falling-edge sampling, period 8 clocks, trigger disabled
    mode = 2'd1; trig_rw = 2'd3; c64_phi2 = 0;
    tick();
    do_arm();
    for (int p = 0; p < 20; p++) begin
      c64_phi2 = 1;
      for (int k = 0; k < 4; k++) begin bus(16'($urandom), 1'($urandom)); tick(); end
      c64_phi2 = 0;
      for (int k = 0; k < 4; k++) begin bus(16'($urandom), 1'($urandom)); tick(); end
    end
    chk("s2_wr_ptr", 32'(wr_ptr), 20);
    chk("s2_armed", 32'(state), 1);
    abort = 1; tick(); abort = 0;
    chk("s2_abort", 32'(state), 0);

    // Write-only trigger on D020
    mode = 0; trig_addr = 16'hD020; trig_rw = 2'd2; post_count = 3;
    do_arm();
    for (int i = 0; i < 3; i++) begin
      do a = 16'($urandom); while (a == 16'hD020);
      bus(a, 1'($urandom)); tick();
    end
    bus(16'hD020, 1); tick();
    chk("s3_read_ignored", 32'(triggered), 0);
    bus(16'hD020, 0); tick();
    chk("s3_write_trig", 32'(triggered), 1);
    chk("s3_trig_index", 32'(trig_index), 4);
    for (int i = 0; i < 3; i++) begin bus(16'hD020, 1); tick(); end
    chk("s3_done", 32'(state), 3);

    // Long run without a trigger wraps the buffer, then external trigger
    trig_rw = 2'd3; ext_trig_en = 1; ext_trig = 0; post_count = 2;
    do_arm();
    for (int i = 0; i < 1500; i++) begin bus(16'($urandom), 1'($urandom)); tick(); end
    chk("s4_wrapped", 32'(wrapped), 1);
    chk("s4_wr_ptr", 32'(wr_ptr), 476);
    chk("s4_armed", 32'(state), 1);
    ext_trig = 1; bus(16'h0000, 1); tick(); ext_trig = 0;
    chk("s4_ext_post", 32'(state), 2);
    chk("s4_ext_index", 32'(trig_index), 476);
    tick(); tick();
    chk("s4_done", 32'(state), 3);

    // post_count 0 with an always-matching trigger, then readback
    ext_trig_en = 0; trig_mask = 0; trig_rw = 0; post_count = 0;
    do_arm();
    read_addr = 0;
    bus(16'hBEEF, 0);
    exp_word = {c64_nmi_n, c64_irq_n, c64_rw, c64_data, c64_addr};
    tick();
    chk("s5_done", 32'(state), 3);
    chk("s5_trig_index", 32'(trig_index), 0);
    bus(16'h0101, 1);
    tick();
    chk("s5_readback", 32'(read_data), 32'(exp_word));

    // Abort in POST, arm+abort together, reset in POST
    post_count = 5;
    do_arm();
    tick();
    chk("s6_post", 32'(state), 2);
    abort = 1; tick(); abort = 0;
    chk("s6_abort_idle", 32'(state), 0);
    chk("s6_abort_trig_held", 32'(triggered), 1);
    arm = 1; abort = 1; tick(); arm = 0; abort = 0;
    chk("s6_arm_abort", 32'(state), 0);
    do_arm();
    tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("s6_rst_state", 32'(state), 0);
    chk("s6_rst_trig", 32'(triggered), 0);
    chk("s6_rst_wr_ptr", 32'(wr_ptr), 0);
    chk("s6_rst_read_data", 32'(read_data), 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (($urandom % 200) == 0) begin
        mode = 2'($urandom); trig_rw = 2'($urandom);
        trig_addr = 16'($urandom); trig_mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
        post_count = (($urandom % 8) == 0) ? 10'd1023 : 10'($urandom % 24);
        ext_trig_en = 1'($urandom);
      end
      c64_phi2  = (($urandom % 3) == 0) ? ~c64_phi2 : c64_phi2;
      arm       = (($urandom % 20) == 0);
      abort     = (($urandom % 150) == 0);
      rst_n     = (($urandom % 700) != 0);
      ext_trig  = (($urandom % 40) == 0);
      read_addr = 10'($urandom);
      bus(16'($urandom), 1'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
